// File: rtl/fpu_wb_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg
// Shared constants and types for the FP writeback scheduler slice.
//   NREG  : FP register count
//   AW    : register index width
//   XLEN  : data width
//   fp_reg_idx_t / fp_word_t : register index and data word types
// Optional feature macro used by the slice: FPU_WB_BYPASS_EN
// ----------------------------------------------------------------------------
package fpu_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int XLEN = 32;

  typedef logic [AW-1:0]   fp_reg_idx_t;
  typedef logic [XLEN-1:0] fp_word_t;

endpackage

// File: rtl/fpu_wb_scheduler_if.sv
// ----------------------------------------------------------------------------
// fpu_wb_scheduler_if
// Bundles the requester bus, issue/check hazard signals and the register-file
// write port of the FP writeback scheduler.
//   req_valid/req_rd/req_data/req_ready : NREQ writeback requesters (packed)
//   iss_valid/iss_rd/iss_ready          : dispatch of an op writing iss_rd
//   chk_rs1/chk_rs2/chk_stall           : source hazard check of op in issue
//   rf_we/rf_wa/rf_wd                   : registerFPU write port
//   busy                                : scoreboard vector
//   byp_hit1/byp_hit2/byp_data          : only with FPU_WB_BYPASS_EN defined
// Modports: slave = scheduler side, master = environment side.
// ----------------------------------------------------------------------------
interface fpu_wb_scheduler_if #(
  parameter int NREQ = 4
);
  import fpu_pkg::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;

  logic        iss_valid;
  fp_reg_idx_t iss_rd;
  logic        iss_ready;

  fp_reg_idx_t chk_rs1;
  fp_reg_idx_t chk_rs2;
  logic        chk_stall;

  logic        rf_we;
  fp_reg_idx_t rf_wa;
  fp_word_t    rf_wd;

  logic [NREG-1:0] busy;

`ifdef FPU_WB_BYPASS_EN
  logic     byp_hit1;
  logic     byp_hit2;
  fp_word_t byp_data;

  modport slave (
    input  req_valid, req_rd, req_data, iss_valid, iss_rd, chk_rs1, chk_rs2,
    output req_ready, iss_ready, chk_stall, rf_we, rf_wa, rf_wd, busy,
           byp_hit1, byp_hit2, byp_data
  );
  modport master (
    output req_valid, req_rd, req_data, iss_valid, iss_rd, chk_rs1, chk_rs2,
    input  req_ready, iss_ready, chk_stall, rf_we, rf_wa, rf_wd, busy,
           byp_hit1, byp_hit2, byp_data
  );
`else
  modport slave (
    input  req_valid, req_rd, req_data, iss_valid, iss_rd, chk_rs1, chk_rs2,
    output req_ready, iss_ready, chk_stall, rf_we, rf_wa, rf_wd, busy
  );
  modport master (
    output req_valid, req_rd, req_data, iss_valid, iss_rd, chk_rs1, chk_rs2,
    input  req_ready, iss_ready, chk_stall, rf_we, rf_wa, rf_wd, busy
  );
`endif

endinterface

// File: rtl/fpu_wb_scheduler_arb.sv
// ----------------------------------------------------------------------------
// fpu_rr_arbiter
// Combinational round-robin arbiter: grants the first requester found when
// searching ptr_i, ptr_i+1, ... modulo NREQ.
//   req_i     : request vector
//   ptr_i     : current priority pointer
//   gnt_o     : one-hot grant (zero when no request)
//   gnt_idx_o : index of granted requester (0 when none)
//   gnt_any_o : a grant was issued
// ----------------------------------------------------------------------------
module fpu_rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   gnt_idx_o,
  output logic            gnt_any_o
);

  always_comb begin
    int idx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      // Rotated search order; NREQ need not be a power of two.
      idx = (int'(ptr_i) + k) % NREQ;
      if (!gnt_any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = PW'(idx);
        gnt_any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_wb_scheduler.sv
// ----------------------------------------------------------------------------
// fpu_wb_scheduler
// Writeback scheduler and scoreboard for the 32-entry FP register file.
// NREQ FP units share the single RF write port through round-robin
// arbitration; the busy vector tracks pending destinations so the issue stage
// stalls on RAW (chk_stall) and WAW (iss_ready) hazards.
//   clk : clock, all state on posedge
//   rst : asynchronous, active-low reset
//   bus : fpu_wb_scheduler_if.slave (requesters, issue/check, RF port, busy)
// Optional: FPU_WB_BYPASS_EN adds byp_hit1/byp_hit2/byp_data and lets a
// source being written this cycle skip its stall.
// ----------------------------------------------------------------------------
module fpu_wb_scheduler
  import fpu_pkg::*;
#(
  parameter int NREQ = 4
) (
  input logic              clk,
  input logic              rst,
  fpu_wb_scheduler_if.slave bus
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rf_we_q;
  fp_reg_idx_t     rf_wa_q, rf_wa_d;
  fp_word_t        rf_wd_q, rf_wd_d;
  logic [NREG-1:0] busy_q, busy_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            iss_ready;

  fpu_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign bus.req_ready = gnt;

  // WAW: a destination already pending blocks dispatch, even if its write
  // lands on this same edge (kept conservative to avoid a same-edge race).
  assign iss_ready     = bus.iss_valid ? ~busy_q[bus.iss_rd] : 1'b1;
  assign bus.iss_ready = iss_ready;

  always_comb begin
    ptr_d   = ptr_q;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    if (gnt_any) begin
      ptr_d   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      rf_wa_d = bus.req_rd[int'(gnt_idx)*AW +: AW];
      rf_wd_d = bus.req_data[int'(gnt_idx)*XLEN +: XLEN];
    end
  end

  // Clear on the edge the RF captures the write, then set; a same-index
  // set therefore wins over the clear.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_wa_q] = 1'b0;
    end
    if (bus.iss_valid && iss_ready) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      rf_we_q <= gnt_any;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.rf_we = rf_we_q;
  assign bus.rf_wa = rf_wa_q;
  assign bus.rf_wd = rf_wd_q;
  assign bus.busy  = busy_q;

`ifdef FPU_WB_BYPASS_EN
  logic hit1, hit2;
  // Only a pending source can hit: a write to a non-busy index is not the
  // producer the consumer is waiting for.
  assign hit1 = rf_we_q & (rf_wa_q == bus.chk_rs1) & busy_q[bus.chk_rs1];
  assign hit2 = rf_we_q & (rf_wa_q == bus.chk_rs2) & busy_q[bus.chk_rs2];
  assign bus.byp_hit1  = hit1;
  assign bus.byp_hit2  = hit2;
  assign bus.byp_data  = rf_wd_q;
  assign bus.chk_stall = (busy_q[bus.chk_rs1] & ~hit1) | (busy_q[bus.chk_rs2] & ~hit2);
`else
  assign bus.chk_stall = busy_q[bus.chk_rs1] | busy_q[bus.chk_rs2];
`endif

endmodule
